// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC sequencer: owns the PC, runs the instruction-memory read
// handshake, fills the IF/ID latch and squashes fetches on a redirect.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | read outstanding at pc; a response is latched or skid-buffered
// SQUASH | redirected while a read is in flight; drop its word, then jump
// HOLD   | decode stalled with a fetched word parked in the skid buffer
module fetch_redirect_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_sel,
    input  logic [15:0] br_target,
    input  logic [15:0] trap_target,
    input  logic [15:0] jmp_target,
    input  logic        stall,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_ir,
    output logic [15:0] if_pc
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] buf_ir_q, buf_ir_d;
    logic [15:0] buf_pc_q, buf_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [15:0] if_ir_q, if_ir_d;
    logic [15:0] if_pc_q, if_pc_d;

    logic        redirect_eff;
    logic [15:0] redirect_raw;
    logic [15:0] redirect_tgt;
    logic [15:0] pc_inc;
    logic        resp_ok;

    // Target select; sel 00 never produces an effective redirect.
    always_comb begin
        redirect_raw = 16'h0000;
        case (redirect_sel)
            2'b01:   redirect_raw = br_target;
            2'b10:   redirect_raw = trap_target;
            2'b11:   redirect_raw = jmp_target;
            default: redirect_raw = 16'h0000;
        endcase
    end

    // Instructions are halfword aligned, so bit 0 of any target is dropped.
    assign redirect_tgt = {redirect_raw[15:1], 1'b0};
    assign redirect_eff = redirect_valid & (redirect_sel != 2'b00);
    assign pc_inc       = pc_q + 16'd2;

    // Reset gates the request combinationally so memory sees it drop at once.
    assign imem_read    = ~reset & (state_q != ST_HOLD);
    assign imem_address = pc_q;
    assign resp_ok      = imem_resp & imem_read;

    assign if_valid = if_valid_q;
    assign if_ir    = if_ir_q;
    assign if_pc    = if_pc_q;

    // Next-state, PC, skid buffer and IF/ID latch update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        buf_ir_d   = buf_ir_q;
        buf_pc_d   = buf_pc_q;
        if_valid_d = if_valid_q;
        if_ir_d    = if_ir_q;
        if_pc_d    = if_pc_q;

        // Decode consumed the latch: a bubble unless something new lands.
        if (!stall) begin
            if_valid_d = 1'b0;
            if_ir_d    = NOP_WORD;
            if_pc_d    = 16'h0000;
        end

        case (state_q)
            ST_FETCH: begin
                if (redirect_eff) begin
                    if (resp_ok) begin
                        pc_d = redirect_tgt;
                    end else begin
                        pending_d = redirect_tgt;
                        state_d   = ST_SQUASH;
                    end
                end else if (resp_ok) begin
                    pc_d = pc_inc;
                    if (stall) begin
                        buf_ir_d = imem_rdata;
                        buf_pc_d = pc_inc;
                        state_d  = ST_HOLD;
                    end else begin
                        if_valid_d = 1'b1;
                        if_ir_d    = imem_rdata;
                        if_pc_d    = pc_inc;
                    end
                end
            end
            ST_SQUASH: begin
                if (resp_ok) begin
                    pc_d    = redirect_eff ? redirect_tgt : pending_q;
                    state_d = ST_FETCH;
                end else if (redirect_eff) begin
                    pending_d = redirect_tgt;
                end
            end
            ST_HOLD: begin
                if (redirect_eff) begin
                    pc_d    = redirect_tgt;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    if_valid_d = 1'b1;
                    if_ir_d    = buf_ir_q;
                    if_pc_d    = buf_pc_q;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // A redirect kills whatever would have been presented to decode.
        if (redirect_eff) begin
            if_valid_d = 1'b0;
            if_ir_d    = NOP_WORD;
            if_pc_d    = 16'h0000;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            pending_q  <= 16'h0000;
            buf_ir_q   <= 16'h0000;
            buf_pc_q   <= 16'h0000;
            if_valid_q <= 1'b0;
            if_ir_q    <= NOP_WORD;
            if_pc_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            buf_ir_q   <= buf_ir_d;
            buf_pc_q   <= buf_pc_d;
            if_valid_q <= if_valid_d;
            if_ir_q    <= if_ir_d;
            if_pc_q    <= if_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a
// transaction-level model of the fetch stage.
module tb_fetch_redirect_unit;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_sel = 2'b00;
    logic [15:0] br_target = 16'h0000;
    logic [15:0] trap_target = 16'h0000;
    logic [15:0] jmp_target = 16'h0000;
    logic        stall = 1'b0;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        if_valid;
    logic [15:0] if_ir;
    logic [15:0] if_pc;

    int checks = 0;
    int errors = 0;

    fetch_redirect_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .br_target      (br_target),
        .trap_target    (trap_target),
        .jmp_target     (jmp_target),
        .stall          (stall),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ir          (if_ir),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the address the fetcher is after, an optional "jump here once the
    // doomed read returns", a list of words parked for decode, and the latch.
    logic [15:0] m_fetch_addr;
    bit          m_doomed;
    logic [15:0] m_after_doom;
    logic [31:0] m_parked[$];
    bit          m_v;
    logic [15:0] m_ir;
    logic [15:0] m_lpc;

    function automatic logic [15:0] chosen_target();
        logic [15:0] t;
        if (redirect_sel == 2'd1)      t = br_target;
        else if (redirect_sel == 2'd2) t = trap_target;
        else                           t = jmp_target;
        return t & 16'hFFFE;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_fetch_addr = 16'h0000;
            m_doomed     = 0;
            m_after_doom = 16'h0000;
            m_parked.delete();
            m_v  = 0;
            m_ir = NOP;
            m_lpc = 16'h0000;
        end else begin
            bit          jump;
            bit          word_back;
            logic [15:0] tgt;
            jump      = redirect_valid && (redirect_sel != 2'd0);
            tgt       = chosen_target();
            word_back = imem_resp && (m_parked.size() == 0);
            if (!stall) begin
                m_v = 0; m_ir = NOP;
            end
            if (m_parked.size() != 0) begin
                if (jump) begin
                    m_parked.delete();
                    m_fetch_addr = tgt;
                end else if (!stall) begin
                    m_v   = 1;
                    m_ir  = m_parked[0][31:16];
                    m_lpc = m_parked[0][15:0];
                    m_parked.delete();
                end
            end else if (m_doomed) begin
                if (word_back) begin
                    m_fetch_addr = jump ? tgt : m_after_doom;
                    m_doomed = 0;
                end else if (jump) begin
                    m_after_doom = tgt;
                end
            end else if (jump) begin
                if (word_back) m_fetch_addr = tgt;
                else begin
                    m_doomed = 1;
                    m_after_doom = tgt;
                end
            end else if (word_back) begin
                if (stall) m_parked.push_back({imem_rdata, 16'(m_fetch_addr + 16'd2)});
                else begin
                    m_v = 1; m_ir = imem_rdata; m_lpc = 16'(m_fetch_addr + 16'd2);
                end
                m_fetch_addr = 16'(m_fetch_addr + 16'd2);
            end
            if (jump) begin
                m_v = 0; m_ir = NOP;
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        bit exp_read;
        exp_read = !reset && (m_parked.size() == 0);
        chk("imem_read", {15'd0, imem_read}, {15'd0, exp_read});
        if (exp_read) chk("imem_address", imem_address, m_fetch_addr);
        chk("if_valid", {15'd0, if_valid}, {15'd0, m_v});
        chk("if_ir", if_ir, m_ir);
        if (m_v) chk("if_pc", if_pc, m_lpc);
    end

    task automatic drive(input logic rsp, input logic [15:0] rd, input logic stl,
                         input logic rv, input logic [1:0] sel, input logic [15:0] tgt);
        imem_resp      = rsp;
        imem_rdata     = rd;
        stall          = stl;
        redirect_valid = rv;
        redirect_sel   = sel;
        br_target      = (sel == 2'd1) ? tgt : 16'h5A5A;
        trap_target    = (sel == 2'd2) ? tgt : 16'hA5A4;
        jmp_target     = (sel == 2'd3) ? tgt : 16'h0F0E;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lat(input string tag, input logic v, input logic [15:0] ir, input logic [15:0] pc);
        chk({tag, "_valid"}, {15'd0, if_valid}, {15'd0, v});
        chk({tag, "_ir"}, if_ir, ir);
        if (v) chk({tag, "_pc"}, if_pc, pc);
    endtask

    task automatic req(input string tag, input logic rd, input logic [15:0] addr);
        chk({tag, "_read"}, {15'd0, imem_read}, {15'd0, rd});
        if (rd) chk({tag, "_addr"}, imem_address, addr);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        req("rst", 1'b0, 16'h0000);
        lat("rst", 1'b0, NOP, 16'h0000);
        chk("rst_pc", if_pc, 16'h0000);
        #2 reset = 1'b0;
        @(negedge clk);
        req("start", 1'b1, 16'h0000);

        drive(1, 16'hA000, 0, 0, 2'd0, 0); lat("seq0", 1, 16'hA000, 16'h0002); req("seq0", 1, 16'h0002);
        drive(1, 16'hA002, 0, 0, 2'd0, 0); lat("seq1", 1, 16'hA002, 16'h0004); req("seq1", 1, 16'h0004);
        drive(1, 16'hA004, 0, 0, 2'd0, 0); lat("seq2", 1, 16'hA004, 16'h0006); req("seq2", 1, 16'h0006);
        drive(1, 16'hA006, 0, 0, 2'd0, 0); lat("seq3", 1, 16'hA006, 16'h0008); req("seq3", 1, 16'h0008);

        drive(0, 16'h0000, 0, 1, 2'd1, 16'h0120); lat("sq0", 0, NOP, 0); req("sq0", 1, 16'h0008);
        drive(1, 16'hDEAD, 0, 0, 2'd0, 0);        lat("sq1", 0, NOP, 0); req("sq1", 1, 16'h0120);
        drive(1, 16'hB120, 0, 0, 2'd0, 0);        lat("sq2", 1, 16'hB120, 16'h0122); req("sq2", 1, 16'h0122);

        drive(1, 16'hC0DE, 0, 1, 2'd2, 16'h0401); lat("trap", 0, NOP, 0); req("trap", 1, 16'h0400);

        drive(1, 16'h5555, 0, 0, 2'd0, 0); lat("pre", 1, 16'h5555, 16'h0402); req("pre", 1, 16'h0402);
        drive(1, 16'h1234, 1, 0, 2'd0, 0); lat("hold0", 1, 16'h5555, 16'h0402); req("hold0", 0, 0);
        drive(1, 16'hEEEE, 1, 0, 2'd0, 0); lat("hold1", 1, 16'h5555, 16'h0402); req("hold1", 0, 0);
        drive(0, 16'h0000, 0, 0, 2'd0, 0); lat("unhold", 1, 16'h1234, 16'h0404); req("unhold", 1, 16'h0404);

        drive(1, 16'h7777, 1, 0, 2'd0, 0);        lat("hj0", 1, 16'h1234, 16'h0404); req("hj0", 0, 0);
        drive(0, 16'h0000, 1, 1, 2'd3, 16'h3000); lat("hj1", 0, NOP, 0); req("hj1", 1, 16'h3000);
        drive(0, 16'h0000, 0, 0, 2'd0, 0);        lat("hj2", 0, NOP, 0); req("hj2", 1, 16'h3000);

        drive(1, 16'h1111, 0, 1, 2'd1, 16'hFFFE); lat("wr0", 0, NOP, 0); req("wr0", 1, 16'hFFFE);
        drive(1, 16'h9999, 0, 0, 2'd0, 0);        lat("wr1", 1, 16'h9999, 16'h0000); req("wr1", 1, 16'h0000);
        drive(1, 16'h8888, 0, 1, 2'd0, 16'h1234); lat("sel0", 1, 16'h8888, 16'h0002); req("sel0", 1, 16'h0002);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
                @(negedge clk);
            end else begin
                imem_resp      = ($urandom_range(9) < 6);
                imem_rdata     = 16'($urandom);
                stall          = ($urandom_range(9) < 3);
                redirect_valid = ($urandom_range(9) < 2);
                redirect_sel   = 2'($urandom_range(3));
                br_target      = 16'($urandom);
                trap_target    = 16'($urandom);
                jmp_target     = 16'($urandom);
                @(posedge clk);
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Fetch-stage PC sequencer for the LC-3b pipeline. It is the consumer of the branch-resolution outputs: a taken/redirect flag plus a 2-bit lc3b_mux_sel target select.
- Owns the PC register and drives the instruction-memory read handshake.
- Fills the IF/ID latch (valid, IR, incremented PC).
- Squashes in-flight or buffered fetches when a redirect arrives, and holds one fetched word in a skid buffer when decode stalls.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_WORD, 16'h0000, IR value presented when the latch is invalid (BR with nzp=000).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- redirect_valid  input  1  redirect taken this cycle (br_taken from resolve logic)
- redirect_sel  input  2  lc3b_mux_sel: 00 none, 01 br_target, 10 trap_target, 11 jmp_target
- br_target  input  16  BR/JSR target address
- trap_target  input  16  trap vector target address
- jmp_target  input  16  JMP/RET base-register target
- stall  input  1  decode cannot accept a new IF/ID entry this cycle
- imem_read  output  1  instruction read request
- imem_address  output  16  instruction read address
- imem_resp  input  1  read complete; imem_rdata valid this cycle
- imem_rdata  input  16  fetched instruction word
- if_valid  output  1  IF/ID latch holds a live instruction
- if_ir  output  16  IF/ID instruction register
- if_pc  output  16  fetch address + 2 of the latched instruction

Behaviour:
Reset (asynchronous, any state):
- pc=RESET_PC, state=FETCH, buf cleared.
- if_valid=0, if_ir=NOP_WORD, if_pc=16'h0000.
- imem_read=0 while reset is high.

Redirect rules:
- A redirect is effective only when redirect_valid=1 and redirect_sel!=00. Valid with sel 00 is ignored.
- Target is selected by redirect_sel. Bit 0 of the target is forced to 0 when loaded.
- An effective redirect always clears if_valid next edge, regardless of stall. if_ir returns to NOP_WORD.

PC arithmetic:
- pc_next = pc + 2, 16-bit modulo: 16'hFFFE wraps to 16'h0000.
- if_pc = fetch address + 2, same wrap rule.

Memory handshake:
- imem_read stays high until imem_resp.
- imem_address is stable and equal to pc while imem_read is high.
- imem_read is 0 in HOLD. In SQUASH it stays high until imem_resp.
- imem_resp is only honoured while imem_read is high.

States:
- FETCH: imem_read=1, imem_address=pc.
  - resp & effective redirect: discard word, pc<=target, stay FETCH. The new address appears next cycle.
  - resp & !stall: latch loads {1, rdata, pc+2}, pc<=pc+2, stay FETCH. This gives back-to-back fetch with one cycle minimum latency, resp to if_valid.
  - resp & stall: word goes to buf with pc+2, pc<=pc+2, go HOLD. The latch keeps its current contents.
  - effective redirect without resp: pending<=target, go SQUASH.
  - neither: stay FETCH.
- SQUASH: imem_read=1 at the old pc.
  - effective redirect again: pending<=new target (latest wins).
  - resp: discard word, pc<=pending, go FETCH.
  - A redirect in the same cycle as resp uses the new target.
- HOLD: imem_read=0.
  - effective redirect: buf discarded, pc<=target, go FETCH.
  - !stall: latch loads buf, go FETCH.
  - stall: remain.

Latch while stall=1 and no redirect:
- if_valid, if_ir and if_pc hold.
- With stall=0 and no resp in FETCH, if_valid<=0 (bubble).

Simultaneous events:
- Redirect beats stall, resp and buffered data.
- Reset beats everything.
- Reset mid-transaction abandons it; the memory sees imem_read drop.

Test Plan:
- Reset then resp every cycle, stall=0 -> addresses 0000,0002,0004. if_ir tracks rdata one cycle after each resp. if_pc = 0002,0004,0006.
- Redirect sel=01 br_target=16'h0120 on the cycle before resp at pc 0008 -> goes to SQUASH. The returned word is dropped and if_valid=0. The next request address is 0120; the first latched if_pc is 0122.
- Redirect sel=10 trap_target=16'h0401 with resp in the same cycle -> word dropped, next imem_address=0400 (bit 0 cleared), no HOLD entry.
- Stall asserted, resp with rdata=16'h1234 -> goes to HOLD with imem_read=0 and the latch unchanged. Stall released -> if_ir=1234, then the fetch resumes at pc+2.
- In HOLD, redirect sel=11 jmp_target=16'h3000 -> buffered word never appears, if_valid=0, next address 3000.
- pc=FFFE fetch completes -> if_pc=0000 and next address 0000. Separately, redirect_valid=1 with sel=00 -> no effect on the sequence.
